// File: rtl/mine_placer_pkg.sv
// Shared minesweeper definitions: generator taps, default seed and placer FSM states.
package mine_placer_pkg;

   localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GEN   = 3'd1,
      ST_CHECK = 3'd2,
      ST_PLACE = 3'd3,
      ST_DONE  = 3'd4
   } placerState_t;

   // Fibonacci x^16+x^14+x^13+x^11+1: feedback enters at the MSB, state shifts right.
   function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
      lfsrNext = {^(cur & LFSR_TAP_MASK), cur[15:1]};
   endfunction

endpackage

// File: rtl/mine_placer_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and single-step enable.
module lfsr16
   import mine_placer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   // Generator state: load has priority over step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= LFSR_DEFAULT_SEED;
      end else if (load) begin
         value <= seed;
      end else if (step) begin
         value <= lfsrNext(value);
      end
   end

endmodule

// File: rtl/mine_placer.sv
// Places numMines distinct mines on a width x height board, avoiding the first-click cell,
// by rejection sampling LFSR candidates against the external mine Board.
module mine_placer
   import mine_placer_pkg::*;
#(
   parameter int width    = 8,
   parameter int height   = 8,
   parameter int numMines = 10
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [15:0]               seed,
   input  logic [$clog2(width)-1:0]  safeX,
   input  logic [$clog2(height)-1:0] safeY,
   output logic [$clog2(width)-1:0]  readX,
   output logic [$clog2(height)-1:0] readY,
   input  logic                      readValue,
   output logic [$clog2(width)-1:0]  placeX,
   output logic [$clog2(height)-1:0] placeY,
   output logic                      placeEn,
   output logic                      busy,
   output logic                      done
);

   localparam int XW = $clog2(width);
   localparam int YW = $clog2(height);
   localparam int CW = $clog2(width * height + 1);

   if ((width < 2) || (width > 16) || (height < 2) || (height > 16)) begin : gBadSize
      $error("mine_placer: width/height must be within 2..16");
   end
   if ((numMines < 1) || (numMines > width * height - 1)) begin : gBadMines
      $error("mine_placer: numMines must be within 1..width*height-1");
   end

   placerState_t    state;
   logic [XW-1:0]   candX;
   logic [YW-1:0]   candY;
   logic [XW-1:0]   safeXReg;
   logic [YW-1:0]   safeYReg;
   logic [CW-1:0]   count;
   logic            startBlocked;
   logic [15:0]     lfsrValue;
   logic [15:0]     loadSeed;
   logic            lfsrLoad;
   logic            lfsrStep;
   logic            accept;
   logic            reject;
   logic            lastMine;

   assign accept   = (state == ST_IDLE) && start && !startBlocked;
   assign loadSeed = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
   assign reject   = (int'(candX) >= width) || (int'(candY) >= height) ||
                     ((candX == safeXReg) && (candY == safeYReg)) || readValue;
   assign lastMine = ((int'(count) + 1) == numMines);

   // The read and write ports always present the current candidate.
   assign readX  = candX;
   assign readY  = candY;
   assign placeX = candX;
   assign placeY = candY;

   // Generator control derived from the current state.
   always_comb begin
      lfsrLoad = 1'b0;
      lfsrStep = 1'b0;
      if (state == ST_IDLE) begin
         lfsrLoad = accept;
      end else if (state == ST_GEN) begin
         lfsrStep = 1'b1;
      end else begin
         lfsrStep = 1'b0;
      end
   end

   lfsr16 uLfsr (
      .clk   (clk),
      .reset (reset),
      .load  (lfsrLoad),
      .step  (lfsrStep),
      .seed  (loadSeed),
      .value (lfsrValue)
   );

   // Placer FSM with registered status and strobe outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         candX        <= '0;
         candY        <= '0;
         safeXReg     <= '0;
         safeYReg     <= '0;
         count        <= '0;
         startBlocked <= 1'b0;
         placeEn      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done    <= 1'b0;
               placeEn <= 1'b0;
               if (accept) begin
                  safeXReg <= safeX;
                  safeYReg <= safeY;
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= ST_GEN;
               end else if (!start) begin
                  startBlocked <= 1'b0;
               end
            end
            // Candidate comes from the post-step generator value.
            ST_GEN: begin
               candX <= XW'(lfsrNext(lfsrValue));
               candY <= YW'(lfsrNext(lfsrValue) >> XW);
               state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (reject) begin
                  state <= ST_GEN;
               end else begin
                  placeEn <= 1'b1;
                  state   <= ST_PLACE;
               end
            end
            ST_PLACE: begin
               placeEn <= 1'b0;
               count   <= count + CW'(1);
               if (lastMine) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  state <= ST_GEN;
               end
            end
            // A start still high here must drop before the next run is accepted.
            ST_DONE: begin
               done         <= 1'b0;
               startBlocked <= start;
               state        <= ST_IDLE;
            end
            default: begin
               placeEn <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
